rst_seq_wdt: RTL and testbench
==============================

# rst_seq_wdt

Parametrised reset sequencer and watchdog for the OpenMIPS SOPC. It takes the board reset and produces CHANNELS synchronised reset outputs that release in a staggered order: core, memories, peripherals. After release, a watchdog cycle counter supervises the running system and either re-runs the reset sequence or latches a timeout. It sits between the board/bench reset source and every reset input of the min SOPC.

## Interface
- CHANNELS, 4: number of reset outputs; at least 1.
- HOLD_CYCLES, 10: cycles all outputs stay asserted after the synchronised deassertion of rst; at least 1.
- STAGGER, 2: cycles between successive channel releases; 0 releases all channels together.
- TIMEOUT_CYCLES, 50: watchdog period in cycles; 0 disables the watchdog.
- REARM, 1: 1 means a timeout restarts the sequence; 0 means a timeout only flags.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sw_rst_i  in  1  synchronous software reset request, active-high.
- kick_i  in  1  watchdog refresh, active-high.
- rst_o  out  CHANNELS  per-channel reset, active-high (`RstEnable`). Assertion is asynchronous; deassertion is synchronous.
- ready_o  out  1  all channels released and running.
- timeout_o  out  1  one-cycle pulse on watchdog expiry.
- timeout_seen_o  out  1  sticky expiry flag; cleared only by rst.

## Operation
- Reset values: rst_o = all ones, ready_o = 0, timeout_o = 0, timeout_seen_o = 0, state = HOLD, counters = 0.
- rst is passed through a 2-flop synchroniser, producing rst_sync_n. The synchroniser asserts asynchronously and deasserts synchronously.
- FSM states:
  - HOLD: counts HOLD_CYCLES cycles while rst_sync_n = 1, then moves to RELEASE.
  - RELEASE: release counter r starts at 0. Channel i deasserts on the cycle where r == i*STAGGER. After channel CHANNELS-1 deasserts, moves to RUN.
  - RUN: ready_o = 1. The watchdog counter increments each cycle and kick_i clears it to 0. On reaching TIMEOUT_CYCLES, timeout_o pulses and timeout_seen_o sets. The FSM then moves to HOLD if REARM = 1, otherwise to EXPIRED.
  - EXPIRED: outputs stay released and ready_o = 1. The watchdog is frozen until rst or sw_rst_i.
- sw_rst_i in any state: on the next edge the FSM enters HOLD, rst_o goes to all ones, ready_o goes to 0, and all counters clear. timeout_seen_o is kept.
- Priority within one cycle: rst > sw_rst_i > kick_i > terminal count. A kick in the same cycle as terminal count suppresses the timeout.
- Counter width: CNT_W = $clog2(max(HOLD_CYCLES, (CHANNELS-1)*STAGGER, TIMEOUT_CYCLES)+1). Counters saturate and never wrap.
- TIMEOUT_CYCLES = 0: the FSM stays in RUN indefinitely and timeout_o is never asserted.
- Re-entering HOLD via REARM: rst_o goes to all ones on the same edge that timeout_o pulses.

## Timing
- Edge 0 is the first clk edge that samples rst = 1. rst_sync_n rises at edge 2.
- rst_o[i] falls at edge 2 + HOLD_CYCLES + i*STAGGER. With defaults, channels 0 to 3 fall at edges 12, 14, 16 and 18.
- ready_o rises on the same edge as rst_o[CHANNELS-1] falls.
- With no kick, timeout_o is high for the single cycle following edge T_ready + TIMEOUT_CYCLES.
- Asserting rst mid-sequence forces all outputs to their reset values immediately, without waiting for a clock.
- sw_rst_i: outputs are asserted 1 cycle after the request. The release timeline then restarts from HOLD without the 2-cycle synchroniser delay.

## Structure
- Shared header defines.v carries:
  - state encodings `RsHold`, `RsRelease`, `RsRun`, `RsExpired` (2 bits);
  - the existing `RstEnable`/`RstDisable` values.
- One sub-module, rst_sync: a 2-flop async-assert/sync-deassert synchroniser, instantiated once on rst.
- Top level contains the FSM, the hold/release counter, the watchdog counter and the output registers.

## Test plan
- Power-on, default parameters: rst low for 195 ns at a 20 ns clock, then high.
  - rst_o[0..3] must fall at edges 12, 14, 16 and 18.
  - ready_o must rise at edge 18.
- No kick after ready: timeout_o must pulse exactly 50 cycles after ready, then timeout_seen_o = 1. All rst_o must re-assert and the sequence must repeat from HOLD.
- Watchdog refresh and REARM = 0:
  - with kick_i every 40 cycles for 500 cycles, timeout_o must stay 0;
  - with REARM = 0 and kicks stopped, the FSM must reach EXPIRED while rst_o stays 0.
- sw_rst_i pulse at edge 15, mid-release: all rst_o must be 1 at edge 16. Release must restart, with channel 0 falling at edge 16 + HOLD_CYCLES.
- kick_i and terminal count in the same cycle: no timeout_o. A second, async rst low mid-RUN must set all outputs to reset values immediately and clear timeout_seen_o.
- Parameter sweep with CHANNELS = 1 and STAGGER = 0, and with TIMEOUT_CYCLES = 0: timing must match the formulas above, and timeout_o must never assert when TIMEOUT_CYCLES = 0.

Source files
------------

// File: rtl/rst_seq_wdt_pkg.sv
// Shared types and constants for the reset sequencer / watchdog.
package rst_seq_wdt_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    RsHold    = 2'd0,
    RsRelease = 2'd1,
    RsRun     = 2'd2,
    RsExpired = 2'd3
  } rs_state_t;

  // Reset polarity of the SOPC reset inputs
  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One counter width serves the hold, release and watchdog phases
  function automatic int cnt_width(input int hold, input int chans,
                                   input int stagger, input int tmo);
    return $clog2(max3(hold, (chans - 1) * stagger, tmo) + 1);
  endfunction

endpackage

// File: rtl/rst_seq_wdt_if.sv
// Control/status bundle between the reset sequencer and its requester.
interface rst_seq_wdt_if #(
  parameter int CHANNELS = 4
);
  logic                sw_rst_i;
  logic                kick_i;
  logic [CHANNELS-1:0] rst_o;
  logic                ready_o;
  logic                timeout_o;
  logic                timeout_seen_o;

  modport master (
    output sw_rst_i, kick_i,
    input  rst_o, ready_o, timeout_o, timeout_seen_o
  );

  modport slave (
    input  sw_rst_i, kick_i,
    output rst_o, ready_o, timeout_o, timeout_seen_o
  );
endinterface

// File: rtl/rst_seq_wdt_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on clk.
module rst_sync (
  input  logic clk,
  input  logic rst,
  output logic rst_sync_n
);

  logic sync_p0;
  logic sync_p1;

  // Shift a one in after rst rises; drop both stages the moment rst falls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= 1'b1;
      sync_p1 <= sync_p0;
    end
  end

  assign rst_sync_n = sync_p1;

endmodule

// File: rtl/rst_seq_wdt.sv
// Staggered reset sequencer with watchdog supervision for the SOPC.
module rst_seq_wdt
  import rst_seq_wdt_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int HOLD_CYCLES    = 10,
  parameter int STAGGER        = 2,
  parameter int TIMEOUT_CYCLES = 50,
  parameter int REARM          = 1
) (
  input logic          clk,
  input logic          rst,
  rst_seq_wdt_if.slave bus
);

  localparam int               CNT_W     = cnt_width(HOLD_CYCLES, CHANNELS, STAGGER, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'((CHANNELS - 1) * STAGGER);
  localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit               WDT_EN    = (TIMEOUT_CYCLES > 0);
  localparam bit               REARM_EN  = (REARM != 0);

  logic                rst_sync_n;
  rs_state_t           state_q;
  logic [CNT_W-1:0]    seq_cnt_q;
  logic [CNT_W-1:0]    wd_cnt_q;
  logic [CHANNELS-1:0] rst_o_q;
  logic [CHANNELS-1:0] rel_hit;
  logic                ready_q;
  logic                timeout_q;
  logic                seen_q;

  // Counters stop at their maximum instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  rst_sync u_rst_sync (
    .clk        (clk),
    .rst        (rst),
    .rst_sync_n (rst_sync_n)
  );

  // Channels whose release slot matches the current release count
  always_comb begin
    rel_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rel_hit[i] = (seq_cnt_q == CNT_W'(i * STAGGER));
    end
  end

  // Sequencer FSM, shared hold/release counter, watchdog and output registers
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q   <= RsHold;
      seq_cnt_q <= '0;
      wd_cnt_q  <= '0;
      rst_o_q   <= {CHANNELS{RstEnable}};
      ready_q   <= 1'b0;
      timeout_q <= 1'b0;
      seen_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (bus.sw_rst_i) begin
        // Software request restarts from HOLD; the sticky flag survives
        state_q   <= RsHold;
        seq_cnt_q <= '0;
        wd_cnt_q  <= '0;
        rst_o_q   <= {CHANNELS{RstEnable}};
        ready_q   <= 1'b0;
      end else begin
        case (state_q)
          RsHold: begin
            if (seq_cnt_q == HOLD_LAST) begin
              state_q   <= RsRelease;
              seq_cnt_q <= '0;
            end else begin
              seq_cnt_q <= sat_inc(seq_cnt_q);
            end
          end
          RsRelease: begin
            for (int i = 0; i < CHANNELS; i++) begin
              if (rel_hit[i]) rst_o_q[i] <= RstDisable;
            end
            if (seq_cnt_q == REL_LAST) begin
              state_q   <= RsRun;
              ready_q   <= 1'b1;
              seq_cnt_q <= '0;
              wd_cnt_q  <= '0;
            end else begin
              seq_cnt_q <= sat_inc(seq_cnt_q);
            end
          end
          RsRun: begin
            if (bus.kick_i) begin
              // A kick wins over a coincident terminal count
              wd_cnt_q <= '0;
            end else if (WDT_EN && (wd_cnt_q == WD_LAST)) begin
              timeout_q <= 1'b1;
              seen_q    <= 1'b1;
              wd_cnt_q  <= '0;
              if (REARM_EN) begin
                state_q   <= RsHold;
                seq_cnt_q <= '0;
                rst_o_q   <= {CHANNELS{RstEnable}};
                ready_q   <= 1'b0;
              end else begin
                state_q <= RsExpired;
              end
            end else begin
              wd_cnt_q <= sat_inc(wd_cnt_q);
            end
          end
          RsExpired: begin
            // Released and frozen until rst or a software request
            state_q <= RsExpired;
          end
          default: begin
            state_q <= RsHold;
          end
        endcase
      end
    end
  end

  assign bus.rst_o          = rst_o_q;
  assign bus.ready_o        = ready_q;
  assign bus.timeout_o      = timeout_q;
  assign bus.timeout_seen_o = seen_q;

endmodule

// File: tb/tb_rst_seq_wdt.sv
// Bench for rst_seq_wdt: four parameterisations driven together against a
// timeline model (release edges, watchdog reference edge, sticky flags).
module tb_rst_seq_wdt;

  localparam int C0 = 4, H0 = 10, S0 = 2, T0 = 50, R0 = 1;
  localparam int C1 = 4, H1 = 10, S1 = 2, T1 = 50, R1 = 0;
  localparam int C2 = 1, H2 = 6,  S2 = 0, T2 = 20, R2 = 1;
  localparam int C3 = 3, H3 = 4,  S3 = 3, T3 = 0,  R3 = 1;

  int P_C [4] = '{C0, C1, C2, C3};
  int P_H [4] = '{H0, H1, H2, H3};
  int P_S [4] = '{S0, S1, S2, S3};
  int P_T [4] = '{T0, T1, T2, T3};
  int P_R [4] = '{R0, R1, R2, R3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw   [4];
  logic kick [4];

  always #10 clk = ~clk;

  rst_seq_wdt_if #(.CHANNELS(C0)) bus0 ();
  rst_seq_wdt_if #(.CHANNELS(C1)) bus1 ();
  rst_seq_wdt_if #(.CHANNELS(C2)) bus2 ();
  rst_seq_wdt_if #(.CHANNELS(C3)) bus3 ();

  assign bus0.sw_rst_i = sw[0];  assign bus0.kick_i = kick[0];
  assign bus1.sw_rst_i = sw[1];  assign bus1.kick_i = kick[1];
  assign bus2.sw_rst_i = sw[2];  assign bus2.kick_i = kick[2];
  assign bus3.sw_rst_i = sw[3];  assign bus3.kick_i = kick[3];

  rst_seq_wdt #(.CHANNELS(C0), .HOLD_CYCLES(H0), .STAGGER(S0), .TIMEOUT_CYCLES(T0), .REARM(R0))
    u0 (.clk(clk), .rst(rst), .bus(bus0));
  rst_seq_wdt #(.CHANNELS(C1), .HOLD_CYCLES(H1), .STAGGER(S1), .TIMEOUT_CYCLES(T1), .REARM(R1))
    u1 (.clk(clk), .rst(rst), .bus(bus1));
  rst_seq_wdt #(.CHANNELS(C2), .HOLD_CYCLES(H2), .STAGGER(S2), .TIMEOUT_CYCLES(T2), .REARM(R2))
    u2 (.clk(clk), .rst(rst), .bus(bus2));
  rst_seq_wdt #(.CHANNELS(C3), .HOLD_CYCLES(H3), .STAGGER(S3), .TIMEOUT_CYCLES(T3), .REARM(R3))
    u3 (.clk(clk), .rst(rst), .bus(bus3));

  logic [3:0] obs_rst  [4];
  logic       obs_rdy  [4];
  logic       obs_to   [4];
  logic       obs_seen [4];

  assign obs_rst[0] = bus0.rst_o;
  assign obs_rst[1] = bus1.rst_o;
  assign obs_rst[2] = {3'b000, bus2.rst_o};
  assign obs_rst[3] = {1'b0, bus3.rst_o};
  assign obs_rdy[0] = bus0.ready_o;  assign obs_to[0] = bus0.timeout_o;  assign obs_seen[0] = bus0.timeout_seen_o;
  assign obs_rdy[1] = bus1.ready_o;  assign obs_to[1] = bus1.timeout_o;  assign obs_seen[1] = bus1.timeout_seen_o;
  assign obs_rdy[2] = bus2.ready_o;  assign obs_to[2] = bus2.timeout_o;  assign obs_seen[2] = bus2.timeout_seen_o;
  assign obs_rdy[3] = bus3.ready_o;  assign obs_to[3] = bus3.timeout_o;  assign obs_seen[3] = bus3.timeout_seen_o;

  // Timeline model: b = edge at which HOLD counting begins, so channel i
  // falls at b + HOLD + i*STAGGER; refe = last watchdog reference edge.
  int ecount = 0;
  int e0     = 0;
  bit in_rst = 1'b1;
  int b       [4];
  int refe    [4];
  bit fired   [4];
  bit seen    [4];
  bit expired [4];

  int vectors     = 0;
  int miscompares = 0;

  int fall   [4][4];
  int rdy_at [4];
  int want_fall [4][4] = '{'{12, 14, 16, 18}, '{12, 14, 16, 18}, '{8, -1, -1, -1}, '{6, 9, 12, -1}};
  int want_rdy  [4]    = '{18, 18, 8, 12};

  function automatic int rdy_edge(int k);
    return b[k] + P_H[k] + (P_C[k] - 1) * P_S[k];
  endfunction

  function automatic logic [6:0] exp_vec(int k);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < P_C[k]; i++) r[i] = in_rst ? 1'b1 : (ecount < b[k] + P_H[k] + i * P_S[k]);
    return {r, !in_rst && (ecount >= rdy_edge(k)), !in_rst && fired[k], seen[k]};
  endfunction

  function automatic logic [6:0] obs_vec(int k);
    return {obs_rst[k], obs_rdy[k], obs_to[k], obs_seen[k]};
  endfunction

  task automatic restart(int k, int base);
    b[k]       = base;
    refe[k]    = rdy_edge(k);
    expired[k] = 1'b0;
  endtask

  task automatic assert_rst();
    rst    = 1'b0;
    in_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fired[k] = 1'b0; seen[k] = 1'b0; expired[k] = 1'b0;
    end
  endtask

  // Advance one clock edge and apply the sequencing rules to the model
  task automatic tick();
    @(posedge clk);
    ecount++;
    if (in_rst) begin
      if (rst) begin
        in_rst = 1'b0;
        e0     = ecount;
        for (int k = 0; k < 4; k++) restart(k, ecount + 2);
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        fired[k] = 1'b0;
        if (sw[k]) restart(k, ecount + 1);
        else if (!expired[k] && ecount > rdy_edge(k)) begin
          if (kick[k]) refe[k] = ecount;
          else if (P_T[k] > 0 && ecount == refe[k] + P_T[k]) begin
            fired[k] = 1'b1;
            seen[k]  = 1'b1;
            if (P_R[k] != 0) restart(k, ecount + 1);
            else expired[k] = 1'b1;
          end
        end
      end
    end
    #2;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #99;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs_vec(k) !== exp_vec(k)) begin
        miscompares++;
        $display("FAIL reset dut%0d: got %b want %b", k, obs_vec(k), exp_vec(k));
      end
    end
    #95 rst = 1'b1;
  endtask

  task automatic test_power_on();
    for (int k = 0; k < 4; k++) begin
      rdy_at[k] = -1;
      for (int i = 0; i < 4; i++) fall[k][i] = -1;
    end
    repeat (22) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL power_on dut%0d edge %0d: got %b want %b", k, ecount - e0, obs_vec(k), exp_vec(k));
        end
        for (int i = 0; i < P_C[k]; i++)
          if (fall[k][i] < 0 && obs_rst[k][i] === 1'b0) fall[k][i] = ecount - e0;
        if (rdy_at[k] < 0 && obs_rdy[k] === 1'b1) rdy_at[k] = ecount - e0;
      end
    end
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < P_C[k]; i++) begin
        vectors++;
        if (fall[k][i] !== want_fall[k][i]) begin
          miscompares++;
          $display("FAIL release_edge dut%0d ch%0d: got edge %0d want %0d", k, i, fall[k][i], want_fall[k][i]);
        end
      end
      vectors++;
      if (rdy_at[k] !== want_rdy[k]) begin
        miscompares++;
        $display("FAIL ready_edge dut%0d: got edge %0d want %0d", k, rdy_at[k], want_rdy[k]);
      end
    end
  endtask

  task automatic test_no_kick();
    int t_to = -1, reas = -1, refall = -1;
    while (ecount - e0 < 100) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL no_kick dut%0d edge %0d: got %b want %b", k, ecount - e0, obs_vec(k), exp_vec(k));
        end
      end
      if (t_to < 0 && obs_to[0] === 1'b1) t_to = ecount - e0;
      if (t_to >= 0 && reas < 0 && obs_rst[0] === 4'hF) reas = ecount - e0;
      if (reas >= 0 && refall < 0 && obs_rst[0][0] === 1'b0) refall = ecount - e0;
    end
    vectors++;
    if (t_to !== 68) begin
      miscompares++;
      $display("FAIL timeout_edge: got %0d want 68", t_to);
    end
    vectors++;
    if (reas !== 68) begin
      miscompares++;
      $display("FAIL rearm_assert_edge: got %0d want 68", reas);
    end
    vectors++;
    if (refall !== 79) begin
      miscompares++;
      $display("FAIL rearm_release_edge: got %0d want 79", refall);
    end
    vectors++;
    if ({obs_rst[1], obs_rdy[1], obs_seen[1]} !== 6'b0000_1_1) begin
      miscompares++;
      $display("FAIL expired_norearm: got %b want 000011", {obs_rst[1], obs_rdy[1], obs_seen[1]});
    end
  endtask

  task automatic test_kick();
    int to_cnt [2] = '{0, 0};
    int next;
    sw[0] = 1'b1; sw[1] = 1'b1;
    tick();
    sw[0] = 1'b0; sw[1] = 1'b0;
    next = $urandom_range(20, 45);
    for (int c = 1; c <= 500; c++) begin
      kick[0] = (c == next); kick[1] = (c == next);
      if (c == next) next = c + $urandom_range(20, 45);
      tick();
      kick[0] = 1'b0; kick[1] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL kick dut%0d cycle %0d: got %b want %b", k, c, obs_vec(k), exp_vec(k));
        end
      end
      if (obs_to[0] === 1'b1) to_cnt[0]++;
      if (obs_to[1] === 1'b1) to_cnt[1]++;
    end
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (to_cnt[k] !== 0) begin
        miscompares++;
        $display("FAIL kick_no_timeout dut%0d: got %0d pulses want 0", k, to_cnt[k]);
      end
    end
  endtask

  task automatic test_expire();
    int to1 = 0;
    repeat (80) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL expire dut%0d edge %0d: got %b want %b", k, ecount - e0, obs_vec(k), exp_vec(k));
        end
      end
      if (obs_to[1] === 1'b1) to1++;
    end
    vectors++;
    if (to1 !== 1) begin
      miscompares++;
      $display("FAIL expire_pulses: got %0d want 1", to1);
    end
    vectors++;
    if ({obs_rst[1], obs_rdy[1], obs_to[1], obs_seen[1]} !== 7'b0000_1_0_1) begin
      miscompares++;
      $display("FAIL expired_state: got %b want 0000101", {obs_rst[1], obs_rdy[1], obs_to[1], obs_seen[1]});
    end
  endtask

  task automatic test_sw_rst();
    int n = 0;
    sw[0] = 1'b1;
    tick();
    sw[0] = 1'b0;
    repeat (13) begin
      tick();
      vectors++;
      if (obs_vec(0) !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL sw_seq edge %0d: got %b want %b", ecount - e0, obs_vec(0), exp_vec(0));
      end
    end
    vectors++;
    if (obs_rst[0] !== 4'b1100) begin
      miscompares++;
      $display("FAIL sw_pre_state: got %b want 1100", obs_rst[0]);
    end
    sw[0] = 1'b1;
    tick();
    sw[0] = 1'b0;
    vectors++;
    if ({obs_rst[0], obs_rdy[0]} !== 5'b1111_0) begin
      miscompares++;
      $display("FAIL sw_assert: got %b want 11110", {obs_rst[0], obs_rdy[0]});
    end
    while (obs_rst[0][0] !== 1'b0 && n < 40) begin
      tick();
      n++;
      vectors++;
      if (obs_vec(0) !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL sw_restart edge %0d: got %b want %b", ecount - e0, obs_vec(0), exp_vec(0));
      end
    end
    vectors++;
    if (n !== 11) begin
      miscompares++;
      $display("FAIL sw_release_delay: got %0d cycles want 11", n);
    end
  endtask

  task automatic test_kick_tc();
    int guard = 0, to0 = 0, tgt;
    tgt = refe[0] + P_T[0];
    while (ecount < tgt - 1 && guard < 300) begin
      tick();
      guard++;
      vectors++;
      if (obs_vec(0) !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL kick_tc_run edge %0d: got %b want %b", ecount - e0, obs_vec(0), exp_vec(0));
      end
      if (obs_to[0] === 1'b1) to0++;
    end
    kick[0] = 1'b1;
    tick();
    kick[0] = 1'b0;
    repeat (10) begin
      vectors++;
      if (obs_vec(0) !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL kick_tc edge %0d: got %b want %b", ecount - e0, obs_vec(0), exp_vec(0));
      end
      if (obs_to[0] === 1'b1) to0++;
      tick();
    end
    vectors++;
    if (to0 !== 0 || ecount < tgt) begin
      miscompares++;
      $display("FAIL kick_tc_suppress: got %0d pulses want 0 (edge %0d target %0d)", to0, ecount, tgt);
    end
    // Asynchronous rst mid-RUN, checked before any clock edge
    #3 assert_rst();
    #1;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs_vec(k) !== exp_vec(k)) begin
        miscompares++;
        $display("FAIL async_rst dut%0d: got %b want %b", k, obs_vec(k), exp_vec(k));
      end
    end
    vectors++;
    if (obs_seen[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst_seen: got %b want 0", obs_seen[1]);
    end
    #3 rst = 1'b1;
    repeat (25) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL re_power_on dut%0d edge %0d: got %b want %b", k, ecount - e0, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_random();
    int to3 = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) begin
        kick[k] = ($urandom_range(0, 29) == 0);
        sw[k]   = ($urandom_range(0, 399) == 0);
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        kick[k] = 1'b0; sw[k] = 1'b0;
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL random dut%0d cycle %0d: got %b want %b", k, c, obs_vec(k), exp_vec(k));
        end
      end
      if (obs_to[3] === 1'b1) to3++;
    end
    vectors++;
    if (to3 !== 0) begin
      miscompares++;
      $display("FAIL wdt_disabled_pulses: got %0d want 0", to3);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      sw[k] = 1'b0; kick[k] = 1'b0;
      b[k] = 0; refe[k] = 0; fired[k] = 1'b0; seen[k] = 1'b0; expired[k] = 1'b0;
    end
    test_reset();
    test_power_on();
    test_no_kick();
    test_kick();
    test_expire();
    test_sw_rst();
    test_kick_tc();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
